// File: rtl/duty_slew_ctrl.sv
// duty_slew_ctrl: feeds the 8-bit PWM generator.
// It accepts a target duty over a valid/ready handshake. It then slews the
// applied duty toward that target by at most STEP per 256-clock PWM period.
// The duty register changes only on the PWM period boundary, so the PWM
// never sees a mid-period change. The estop input overrides everything and
// forces duty to 0.
//
// Handshake: a target transfers on a rising clk edge where tgt_vld and
// tgt_rdy are both high. tgt_rdy is combinational and is high only in IDLE
// with estop low. The producer must hold tgt_duty stable while tgt_vld is
// high and tgt_rdy is low.
module duty_slew_ctrl #(
   parameter int STEP = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] tgt_duty,
   input  logic       tgt_vld,
   output logic       tgt_rdy,
   input  logic       estop,
   output logic [7:0] duty,
   output logic       ramping,
   output logic       done
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RAMP = 2'd1,
      STOP = 2'd2
   } state_t;

   localparam logic [8:0] STEP9 = 9'(STEP);
   localparam logic [7:0] STEP8 = 8'(STEP);

   state_t     state;
   logic [7:0] target;
   logic [7:0] cnt;
   logic       upd;
   logic [8:0] diff;
   logic [8:0] mag;

   // PWM period counter; it shares rst_n with the PWM so both stay aligned
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= 8'd0;
      end else begin
         cnt <= cnt + 8'd1;
      end
   end

   // Distance to target as a 9-bit two's complement value, plus its magnitude
   always_comb begin
      upd  = (cnt == 8'hFF);
      diff = {1'b0, target} - {1'b0, duty};
      mag  = diff[8] ? (~diff + 9'd1) : diff;
   end

   // Handshake and status outputs are decoded straight from the state register
   always_comb begin
      tgt_rdy = (state == IDLE) && !estop;
      ramping = (state == RAMP);
   end

   // Control FSM; estop has top priority, duty only moves on the upd edge
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         duty   <= 8'd0;
         target <= 8'd0;
         done   <= 1'b0;
      end else begin
         done <= 1'b0;
         if (estop) begin
            state  <= STOP;
            duty   <= 8'd0;
            target <= 8'd0;
         end else begin
            case (state)
               IDLE: begin
                  if (tgt_vld) begin
                     target <= tgt_duty;
                     if (tgt_duty == duty) begin
                        done <= 1'b1;
                     end else begin
                        state <= RAMP;
                     end
                  end
               end
               RAMP: begin
                  if (upd) begin
                     // The last step is clamped to the target, so duty can never wrap
                     if (mag <= STEP9) begin
                        duty  <= target;
                        done  <= 1'b1;
                        state <= IDLE;
                     end else if (diff[8]) begin
                        duty <= duty - STEP8;
                     end else begin
                        duty <= duty + STEP8;
                     end
                  end
               end
               STOP: begin
                  state <= IDLE;
               end
               default: begin
                  state <= IDLE;
               end
            endcase
         end
      end
   end

endmodule
